decode_ibuf: RTL and testbench

Parametrised instruction holding buffer between the instruction-memory read port and the decode stage. It replaces the fixed two-cycle `was_stall` capture with a FIFO sized to the memory read latency, so that no in-flight fetch response is lost while decode stalls. It also presents either a zero-latency bypass of the incoming response or the oldest buffered entry to decode, and throttles fetch with a credit-style `fetch_stall`. Width, depth and memory latency are parameters, and the per-entry fetch exception code travels with each instruction.

---
 rtl/decode_ibuf.sv | 130 +++++++++++++
 tb/tb_decode_ibuf.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_ibuf.sv
// Instruction holding buffer between the instruction-memory read port and decode.
// Bypasses the response when empty, otherwise presents the oldest entry; throttles fetch by credit.
module decode_ibuf #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned EXC_W       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [XLEN-1:0]              mem_out_0,
    input  logic [XLEN-1:0]              pc_in,
    input  logic [EXC_W-1:0]             exc_in,
    input  logic                         bubble_in,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         halt,
    output logic [XLEN-1:0]              instr_out,
    output logic [XLEN-1:0]              pc_out,
    output logic [EXC_W-1:0]             exc_out,
    output logic                         bubble_out,
    output logic                         fetch_stall,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
    localparam logic [CntW-1:0] StallThr = CntW'(DEPTH - MEM_LATENCY);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 4 || DEPTH < MEM_LATENCY + 1) begin : g_param_check
        $error("decode_ibuf: need 1 <= MEM_LATENCY <= 4 and DEPTH >= MEM_LATENCY + 1");
    end

    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [EXC_W-1:0] exc_mem   [DEPTH];

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [PtrW-1:0] wr_q, wr_d;
    logic            ovf_q, ovf_d;

    logic arrive;
    logic empty;
    logic is_full;
    logic take;
    logic rd_en;
    logic wr_en;
    logic drop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        arrive  = !bubble_in && !flush && !halt;
        empty   = (count_q == '0);
        is_full = (count_q == FullCnt);

        if (empty) begin
            instr_out  = mem_out_0;
            pc_out     = pc_in;
            exc_out    = exc_in;
            bubble_out = !arrive;
        end else begin
            instr_out  = instr_mem[rd_q];
            pc_out     = pc_mem[rd_q];
            exc_out    = exc_mem[rd_q];
            bubble_out = flush;
        end

        take  = !bubble_out && !stall && !halt;
        rd_en = take && !empty;
        // A full buffer can still accept an arrival when the head leaves in the same cycle.
        drop  = arrive && is_full && !take;
        wr_en = arrive && !(empty && take) && !drop;
    end

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ovf_d   = ovf_q | drop;

        if (flush && !halt) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (rd_en) rd_d = ptr_inc(rd_q);
            if (wr_en) wr_d = ptr_inc(wr_q);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is data-only; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[wr_q] <= mem_out_0;
            pc_mem[wr_q]    <= pc_in;
            exc_mem[wr_q]   <= exc_in;
        end
    end

    assign fetch_stall  = (count_q >= StallThr);
    assign count        = count_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_decode_ibuf.sv
// Scoreboard bench for decode_ibuf: directed scenarios then randomized traffic,
// checked against a queue-based model of the buffer contents.
module tb_decode_ibuf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_out_0 = '0;
    logic [31:0] pc_in = '0;
    logic [7:0]  exc_in = '0;
    logic        bubble_in = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [7:0]  exc_out;
    logic        bubble_out;
    logic        fetch_stall;
    logic [2:0]  count;
    logic        overflow_err;

    decode_ibuf #(
        .XLEN(32), .EXC_W(8), .DEPTH(DEPTH), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_out_0(mem_out_0), .pc_in(pc_in), .exc_in(exc_in),
        .bubble_in(bubble_in), .stall(stall), .flush(flush), .halt(halt),
        .instr_out(instr_out), .pc_out(pc_out), .exc_out(exc_out), .bubble_out(bubble_out),
        .fetch_stall(fetch_stall), .count(count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  exc;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic ovf = 1'b0;
    logic pend_ovf = 1'b0;
    logic pend_flush = 1'b0;
    logic chk_en = 1'b0;
    int   exp_count = 0;
    logic exp_bub = 1'b1;
    logic exp_fs = 1'b0;
    logic exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] p);
        return {p[15:0], ~p[15:0]};
    endfunction

    // One cycle of stimulus; the model predicts outputs and queues accepted instructions.
    task automatic cyc(input logic b, input logic [31:0] p, input logic [7:0] e,
                       input logic s, input logic f, input logic h);
        int   n;
        logic arr, pres, tk;
        ent_t it;
        @(posedge clk);
        if (pend_flush) sb.delete();
        if (pend_ovf) ovf = 1'b1;
        pend_flush = 1'b0;
        pend_ovf   = 1'b0;
        #1;
        bubble_in = b; pc_in = p; mem_out_0 = mk_instr(p); exc_in = e;
        stall = s; flush = f; halt = h;
        n    = sb.size();
        arr  = !b && !f && !h;
        pres = (n > 0) ? !f : arr;
        tk   = pres && !s && !h;
        if (arr) begin
            if (n == DEPTH && !tk) begin
                pend_ovf = 1'b1;
            end else begin
                it.instr = mk_instr(p);
                it.pc    = p;
                it.exc   = e;
                sb.push_back(it);
            end
        end
        pend_flush = f && !h;
        exp_count  = n;
        exp_bub    = !pres;
        exp_fs     = (n >= DEPTH - LAT);
        exp_ovf    = ovf;
        chk_en     = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle status checks, and pops the scoreboard whenever decode takes.
    always @(negedge clk) begin
        ent_t e;
        if (chk_en && rst_n) begin
            chk("count", 32'(count), 32'(exp_count));
            chk("bubble_out", 32'(bubble_out), 32'(exp_bub));
            chk("fetch_stall", 32'(fetch_stall), 32'(exp_fs));
            chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
            if (!bubble_out && !stall && !halt) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_take: pc %0h presented with nothing expected at %0t",
                             pc_out, $time);
                end else begin
                    e = sb.pop_front();
                    chk("pc_out", pc_out, e.pc);
                    chk("instr_out", instr_out, e.instr);
                    chk("exc_out", 32'(exc_out), 32'(e.exc));
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_bubble", 32'(bubble_out), 32'h1);
        chk("reset_fetch_stall", 32'(fetch_stall), 32'h0);
        chk("reset_overflow", 32'(overflow_err), 32'h0);
        rst_n = 1'b1;

        // Bypass
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h100 + 32'(4 * i), 8'h0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Stall capture then release
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h200 + 32'(4 * i), 8'h0, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Simultaneous take and arrival across several pointer wraps
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'h300 + 32'(4 * i), 8'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i < 14; i++) cyc(1'b0, 32'h300 + 32'(4 * i), 8'h0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Flush with stall while an arrival is present
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h400 + 32'(4 * i), 8'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h40C, 8'h0, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Exception code travels with a buffered entry
        cyc(1'b0, 32'h700, 8'h81, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Overflow: five arrivals ignoring fetch_stall
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h600 + 32'(4 * i), 8'h0, 1'b1, 1'b0, 1'b0);
        idle(6);

        // Halt freezes state even with arrival and flush
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'h500 + 32'(4 * i), 8'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h508, 8'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h50C, 8'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h510, 8'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-stall
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        bubble_in = 1'b1; stall = 1'b1; flush = 1'b0; halt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_count", 32'(count), 32'h0);
        chk("midreset_overflow", 32'(overflow_err), 32'h0);
        chk("midreset_bubble", 32'(bubble_out), 32'h1);
        sb.delete();
        ovf = 1'b0; pend_ovf = 1'b0; pend_flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic
        pc = 32'h1000;
        for (int i = 0; i < 1500; i++) begin
            logic b, s, f, h;
            logic [7:0] e;
            b = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 39) == 0);
            h = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h0;
            cyc(b, pc, e, s, f, h);
            if (!b) pc = pc + 32'd4;
        end
        idle(6);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
